ddr3_hls_gmem_fifo_ex: RTL and testbench
========================================

// Module: ddr3_hls_gmem_fifo_ex
// PURPOSE
//  Parametrised successor to the gmem m_axi buffering FIFO in the DDR3 HLS write path.
//  Adds:
//  - selectable first-word-fall-through (FWFT) or standard read mode
//  - non-power-of-two depth
//  - almost-full / almost-empty thresholds
//  - synchronous flush
//  - sticky overflow / underflow flags
//  Buffers AXI write data/addresses between the HLS core and the m_axi burst engine.
// PARAMETERS
//  DATA_BITS     8   data word width
//  DEPTH         16  capacity in words, >=2, any integer
//  DEPTH_BITS    5   count width; must satisfy 2**DEPTH_BITS > DEPTH
//  FWFT          1   1: q shows head word while empty_n=1; 0: q valid 1 cycle after pop
//  AFULL_THRESH  12  almost_full asserted when count >= AFULL_THRESH
//  AEMPTY_THRESH 2   almost_empty asserted when count <= AEMPTY_THRESH
// PORTS
//  sclk         in   1           clock
//  reset        in   1           synchronous, active-high reset
//  sclk_en      in   1           clock enable; 0 freezes all state
//  flush        in   1           synchronous discard of all contents
//  wrreq        in   1           write request
//  data         in   DATA_BITS   write data
//  full_n       out  1           1 = space available
//  almost_full  out  1           count >= AFULL_THRESH
//  rdreq        in   1           read request
//  q            out  DATA_BITS   read data
//  empty_n      out  1           1 = data available
//  almost_empty out  1           count <= AEMPTY_THRESH
//  data_count   out  DEPTH_BITS  words held, 0..DEPTH
//  overflow     out  1           sticky: write attempted while full
//  underflow    out  1           sticky: read attempted while empty
// BEHAVIOUR
//  Reset and status outputs
//  - Reset (sclk edge, reset=1): count=0, pointers=0, q=0, empty_n=0, full_n=1,
//    almost_full=0, almost_empty=1, overflow=0, underflow=0. Reset has priority over everything.
//  - All outputs are registered. Flags are updated in the same edge as count, so they are
//    always consistent with data_count.
//  Handshake
//  - push = wrreq & full_n & sclk_en.
//  - pop  = rdreq & empty_n & sclk_en.
//  - full_n = (count != DEPTH); empty_n = (count != 0).
//  - A write while full is rejected even if a pop occurs in the same cycle.
//  - A read while empty is rejected even if a push occurs in the same cycle.
//  - Simultaneous push and pop: count is unchanged.
//  - Otherwise count is +1 on push, -1 on pop.
//  Read modes
//  - FWFT=1: q always holds the head word while empty_n=1.
//    - A push into an empty FIFO gives empty_n=1 with q=data at the next edge (bypass, 1-cycle latency).
//    - On pop, q updates to the next word at the same edge, or holds its value if the FIFO becomes empty.
//  - FWFT=0: on pop, q is loaded with the head word at that edge; it is valid the cycle after rdreq.
//    q holds its value when there is no pop.
//  Pointers
//  - wr and rd pointers range 0..DEPTH-1 and wrap from DEPTH-1 to 0 (no power-of-two assumption).
//  - Memory is written only on push.
//  Flush
//  - flush=1 acts regardless of sclk_en and has priority over push/pop.
//  - count and pointers go to 0, empty_n=0, full_n=1, overflow and underflow are cleared, q holds.
//  - wrreq/rdreq in a flush cycle are ignored and raise no error flags.
//  Error flags
//  - overflow  set on wrreq & ~full_n & sclk_en & ~flush.
//  - underflow set on rdreq & ~empty_n & sclk_en & ~flush.
//  - Both stay set until reset or flush.
//  Clock enable
//  - sclk_en=0: no state changes (memory, q, count, flags), except reset and flush.
//  Reset mid-burst
//  - All data is discarded. The first word written after reset is the first word read.
// TESTING
//  1. Fill/drain, DEPTH=5, FWFT=1: write 0x10..0x14 -> full_n=0 after the 5th push, data_count=5;
//     read 5 -> q sequence 0x10..0x14, then empty_n=0.
//  2. Wrap, DEPTH=5: 3 writes, 3 reads, then 5 writes -> pointers wrap 4->0;
//     read order is preserved, no data loss.
//  3. Simultaneous push/pop at count=3 for 10 cycles -> data_count stays 3, output order correct.
//     Write at full with rdreq -> write rejected, overflow=1.
//  4. FWFT=0 latency: push 0xA5 into empty, rdreq next cycle -> q=0xA5 one cycle after rdreq.
//     rdreq while empty -> underflow=1, q unchanged.
//  5. Thresholds, AFULL=4, AEMPTY=1: step count 0..5..0 -> almost_full=1 exactly for count>=4,
//     almost_empty=1 exactly for count<=1.
//  6. Flush at count=3 with sclk_en=0 -> data_count=0, empty_n=0, flags cleared.
//     Next push of 0x3C is read back first.

Source files
------------

// File: rtl/ddr3_hls_gmem_fifo_ex.sv
`default_nettype none
// ============================================================================
//  Module      : ddr3_hls_gmem_fifo_ex
//  Description : Synchronous gmem buffering FIFO with FWFT/standard read mode,
//                arbitrary depth, level thresholds, flush and sticky error flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module ddr3_hls_gmem_fifo_ex #(
    parameter int DATA_BITS     = 8,
    parameter int DEPTH         = 16,
    parameter int DEPTH_BITS    = 5,
    parameter int FWFT          = 1,
    parameter int AFULL_THRESH  = 12,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                  sclk,
    input  logic                  reset,
    input  logic                  sclk_en,
    input  logic                  flush,
    input  logic                  wrreq,
    input  logic [DATA_BITS-1:0]  data,
    output logic                  full_n,
    output logic                  almost_full,
    input  logic                  rdreq,
    output logic [DATA_BITS-1:0]  q,
    output logic                  empty_n,
    output logic                  almost_empty,
    output logic [DEPTH_BITS-1:0] data_count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int c_addr_bits = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_addr_bits-1:0] c_last_addr = c_addr_bits'(DEPTH - 1);
    localparam logic [DEPTH_BITS-1:0]  c_depth     = DEPTH_BITS'(DEPTH);
    localparam logic [DEPTH_BITS-1:0]  c_afull     = DEPTH_BITS'(AFULL_THRESH);
    localparam logic [DEPTH_BITS-1:0]  c_aempty    = DEPTH_BITS'(AEMPTY_THRESH);
    localparam logic [DEPTH_BITS-1:0]  c_one       = DEPTH_BITS'(1);

    logic [DATA_BITS-1:0]   r_mem [0:DEPTH-1];
    logic [c_addr_bits-1:0] r_wr_ptr, r_rd_ptr;
    logic [DEPTH_BITS-1:0]  r_count;
    logic [DATA_BITS-1:0]   r_q;
    logic                   r_empty_n, r_full_n, r_almost_full, r_almost_empty;
    logic                   r_overflow, r_underflow;

    logic                   w_push, w_pop;
    logic [c_addr_bits-1:0] w_wr_ptr_nxt, w_rd_ptr_nxt;
    logic [DEPTH_BITS-1:0]  w_count_nxt;
    logic [DATA_BITS-1:0]   w_q_nxt;

    always_comb begin
        w_push       = wrreq & r_full_n & sclk_en & ~flush;
        w_pop        = rdreq & r_empty_n & sclk_en & ~flush;
        w_wr_ptr_nxt = (r_wr_ptr == c_last_addr) ? '0 : r_wr_ptr + 1'b1;
        w_rd_ptr_nxt = (r_rd_ptr == c_last_addr) ? '0 : r_rd_ptr + 1'b1;

        w_count_nxt = r_count;
        if (flush)
            w_count_nxt = '0;
        else if (w_push && !w_pop)
            w_count_nxt = r_count + 1'b1;
        else if (w_pop && !w_push)
            w_count_nxt = r_count - 1'b1;

        // FWFT keeps q equal to the head word; the bypass covers a push that
        // lands while the queue is (or becomes) otherwise empty.
        w_q_nxt = r_q;
        if (FWFT != 0) begin
            if (w_push && (r_count == '0))
                w_q_nxt = data;
            else if (w_pop) begin
                if (r_count > c_one)
                    w_q_nxt = r_mem[w_rd_ptr_nxt];
                else if (w_push)
                    w_q_nxt = data;
            end
        end else if (w_pop) begin
            w_q_nxt = r_mem[r_rd_ptr];
        end
    end

    always_ff @(posedge sclk) begin
        if (!reset && w_push)
            r_mem[r_wr_ptr] <= data;
    end

    always_ff @(posedge sclk) begin
        if (reset) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_q            <= '0;
            r_empty_n      <= 1'b0;
            r_full_n       <= 1'b1;
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
            r_overflow     <= 1'b0;
            r_underflow    <= 1'b0;
        end else begin
            r_count        <= w_count_nxt;
            r_q            <= w_q_nxt;
            r_empty_n      <= (w_count_nxt != '0);
            r_full_n       <= (w_count_nxt != c_depth);
            r_almost_full  <= (w_count_nxt >= c_afull);
            r_almost_empty <= (w_count_nxt <= c_aempty);
            if (flush) begin
                r_wr_ptr    <= '0;
                r_rd_ptr    <= '0;
                r_overflow  <= 1'b0;
                r_underflow <= 1'b0;
            end else begin
                if (w_push)
                    r_wr_ptr <= w_wr_ptr_nxt;
                if (w_pop)
                    r_rd_ptr <= w_rd_ptr_nxt;
                if (wrreq && !r_full_n && sclk_en)
                    r_overflow <= 1'b1;
                if (rdreq && !r_empty_n && sclk_en)
                    r_underflow <= 1'b1;
            end
        end
    end

    assign q            = r_q;
    assign empty_n      = r_empty_n;
    assign full_n       = r_full_n;
    assign almost_full  = r_almost_full;
    assign almost_empty = r_almost_empty;
    assign data_count   = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_ddr3_hls_gmem_fifo_ex.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ddr3_hls_gmem_fifo_ex
//  Description : Directed and random stimulus against a queue-based model for
//                both FWFT and standard read-mode instances (DEPTH=5).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ddr3_hls_gmem_fifo_ex;

    localparam int DEPTH = 5;
    localparam int DW    = 8;
    localparam int DB    = 3;
    localparam int AF    = 4;
    localparam int AE    = 1;

    logic          sclk = 1'b0;
    logic          reset = 1'b1, sclk_en = 1'b1, flush = 1'b0;
    logic          wrreq = 1'b0, rdreq = 1'b0;
    logic [DW-1:0] data = '0;

    logic [DW-1:0] fw_q, sd_q;
    logic [DB-1:0] fw_count, sd_count;
    logic fw_full_n, fw_afull, fw_empty_n, fw_aempty, fw_ovf, fw_unf;
    logic sd_full_n, sd_afull, sd_empty_n, sd_aempty, sd_ovf, sd_unf;

    always #5 sclk = ~sclk;

    ddr3_hls_gmem_fifo_ex #(.DATA_BITS(DW), .DEPTH(DEPTH), .DEPTH_BITS(DB), .FWFT(1),
                            .AFULL_THRESH(AF), .AEMPTY_THRESH(AE)) u_fw (
        .sclk(sclk), .reset(reset), .sclk_en(sclk_en), .flush(flush),
        .wrreq(wrreq), .data(data), .full_n(fw_full_n), .almost_full(fw_afull),
        .rdreq(rdreq), .q(fw_q), .empty_n(fw_empty_n), .almost_empty(fw_aempty),
        .data_count(fw_count), .overflow(fw_ovf), .underflow(fw_unf));

    ddr3_hls_gmem_fifo_ex #(.DATA_BITS(DW), .DEPTH(DEPTH), .DEPTH_BITS(DB), .FWFT(0),
                            .AFULL_THRESH(AF), .AEMPTY_THRESH(AE)) u_sd (
        .sclk(sclk), .reset(reset), .sclk_en(sclk_en), .flush(flush),
        .wrreq(wrreq), .data(data), .full_n(sd_full_n), .almost_full(sd_afull),
        .rdreq(rdreq), .q(sd_q), .empty_n(sd_empty_n), .almost_empty(sd_aempty),
        .data_count(sd_count), .overflow(sd_ovf), .underflow(sd_unf));

    int checks   = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reference model: a plain queue plus the two read-port registers.
    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_q_fw = '0, m_q_sd = '0;
    logic          m_ovf = 1'b0, m_unf = 1'b0;

    task automatic model_update();
        int n;
        n = mq.size();
        if (reset) begin
            mq.delete();
            m_q_fw = '0; m_q_sd = '0; m_ovf = 1'b0; m_unf = 1'b0;
        end else if (flush) begin
            mq.delete();
            m_ovf = 1'b0; m_unf = 1'b0;
        end else if (sclk_en) begin
            if (wrreq && n == DEPTH) m_ovf = 1'b1;
            if (rdreq && n == 0)     m_unf = 1'b1;
            if (rdreq && n > 0)      m_q_sd = mq.pop_front();
            if (wrreq && n < DEPTH)  mq.push_back(data);
            if (mq.size() > 0)       m_q_fw = mq[0];
        end
    endtask

    task automatic compare_all();
        int n;
        n = mq.size();
        check_val("fw.q",       fw_q,       m_q_fw);
        check_val("sd.q",       sd_q,       m_q_sd);
        check_val("fw.count",   fw_count,   n);
        check_val("sd.count",   sd_count,   n);
        check_val("fw.empty_n", fw_empty_n, n != 0);
        check_val("sd.empty_n", sd_empty_n, n != 0);
        check_val("fw.full_n",  fw_full_n,  n != DEPTH);
        check_val("sd.full_n",  sd_full_n,  n != DEPTH);
        check_val("fw.afull",   fw_afull,   n >= AF);
        check_val("sd.afull",   sd_afull,   n >= AF);
        check_val("fw.aempty",  fw_aempty,  n <= AE);
        check_val("sd.aempty",  sd_aempty,  n <= AE);
        check_val("fw.ovf",     fw_ovf,     m_ovf);
        check_val("sd.ovf",     sd_ovf,     m_ovf);
        check_val("fw.unf",     fw_unf,     m_unf);
        check_val("sd.unf",     sd_unf,     m_unf);
    endtask

    task automatic cyc(input logic w, input logic r, input logic [DW-1:0] d,
                       input logic en, input logic fl, input logic rs);
        wrreq = w; rdreq = r; data = d; sclk_en = en; flush = fl; reset = rs;
        @(posedge sclk);
        model_update();
        #1;
        compare_all();
    endtask

    initial begin
        cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        // fill to full, then drain
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b0, 8'(8'h10 + i), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) cyc(1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
        // pointer wrap
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 8'(8'h20 + i), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'(8'h30 + i), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
        // steady push/pop at count 3, then write at full with rdreq
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 8'(8'h40 + i), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, 8'(8'h50 + i), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) cyc(1'b1, 1'b0, 8'(8'h60 + i), 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 8'hEE, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
        // flush at count 3 with clock enable low, then a fresh word
        cyc(1'b1, 1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
        // standard-mode latency from empty, then reads while empty
        cyc(1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
        // frozen clock enable, then reset mid-burst
        cyc(1'b1, 1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 8'(8'h70 + i), 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 8'hAB, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
        // randomized traffic
        for (int i = 0; i < 800; i++)
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
                1'(($urandom % 8) != 0), 1'(($urandom % 40) == 0), 1'(($urandom % 150) == 0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
